// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like port to an AXI4 read master.
// Keeps up to OUTSTANDING in-order single-beat reads and can discard in-flight fetches on cancel.
module inst_sram_axi_bridge #(
    parameter int         OUTSTANDING = 2,
    parameter logic [3:0] ARID        = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,
    input  logic        cancel,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic {
        IDLE,
        ADDR
    } state_t;

    localparam logic [1:0] MAX_CNT = 2'(OUTSTANDING);

    state_t      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic        dataok_q, dataok_d;
    logic [31:0] rdata_q, rdata_d;

    logic addr_ok;
    logic r_hs;
    logic unused_inputs;

    assign addr_ok = (state_q == IDLE) && inst_sram_req && (cnt_q < MAX_CNT);
    // A beat arriving with nothing outstanding is a slave protocol violation; ignore it.
    assign r_hs    = rvalid && (cnt_q != 2'd0);

    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        size_d     = size_q;
        drop_cnt_d = drop_cnt_q;
        dataok_d   = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (addr_ok) begin
                    state_d   = ADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = inst_sram_addr;
                    size_d    = inst_sram_size;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q + {1'b0, addr_ok} - {1'b0, r_hs};

        // Cancel marks every read still owed by the slave, including one accepted right now.
        if (cancel) begin
            drop_cnt_d = cnt_d;
        end else if (r_hs && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end

        if (r_hs && (drop_cnt_q == 2'd0) && !cancel) begin
            dataok_d = 1'b1;
            rdata_d  = rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= 32'd0;
            size_q     <= 2'd0;
            cnt_q      <= 2'd0;
            drop_cnt_q <= 2'd0;
            dataok_q   <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
            dataok_q   <= dataok_d;
            rdata_q    <= rdata_d;
        end
    end

    assign inst_sram_addrok = addr_ok;
    assign inst_sram_dataok = dataok_q;
    assign inst_sram_rdata  = rdata_q;

    assign arid    = ARID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = 1'b1;

    assign unused_inputs = ^{inst_sram_wr, inst_sram_wdata, rid, rresp, rlast};

endmodule
